// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-back scoreboard for the
// dual-issue pipeline. Combinational reads with same-cycle write bypass,
// synchronous writes (youngest port wins), and a per-register busy bit set by
// decode marks and cleared by write-back or flush. Register 0 reads as zero.
module regfile_mp #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_READ  = 4,
  parameter int unsigned NUM_WRITE = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_READ*ADDR_W-1:0]    rd_addr,
  output logic [NUM_READ*DATA_W-1:0]    rd_data,
  output logic [NUM_READ-1:0]           rd_busy,
  input  logic [NUM_WRITE-1:0]          wr_en,
  input  logic [NUM_WRITE*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WRITE*DATA_W-1:0]   wr_data,
  input  logic [NUM_WRITE-1:0]          mark_en,
  input  logic [NUM_WRITE*ADDR_W-1:0]   mark_addr,
  input  logic                          flush
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Architectural state: entry 0 is not stored, busy[0] is held at zero.
  logic [DATA_W-1:0] r_regs [1:DEPTH-1];
  logic [DEPTH-1:0]  r_busy;

  // Per-register write/mark decode and next-state values.
  logic [DEPTH-1:0]  w_wr_hit;
  logic [DEPTH-1:0]  w_mark_hit;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [DATA_W-1:0] w_reg_nxt [1:DEPTH-1];

  // Read-port intermediates.
  logic [ADDR_W-1:0] w_rd_addr [NUM_READ];
  logic [DATA_W-1:0] w_rd_data [NUM_READ];
  logic [NUM_READ-1:0] w_rd_busy;

  // Decode write and mark ports per register; the higher write port index overrides.
  always_comb begin
    w_wr_hit   = '0;
    w_mark_hit = '0;
    for (int r = 1; r < int'(DEPTH); r++) begin
      w_reg_nxt[r] = r_regs[r];
      for (int j = 0; j < int'(NUM_WRITE); j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          w_wr_hit[r]  = 1'b1;
          w_reg_nxt[r] = wr_data[j*DATA_W +: DATA_W];
        end
        if (mark_en[j] && (mark_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          w_mark_hit[r] = 1'b1;
        end
      end
    end
  end

  // Scoreboard next state: flush beats a new mark, a new mark beats a completing write.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < int'(DEPTH); r++) begin
      if (flush) begin
        w_busy_nxt[r] = 1'b0;
      end else if (w_mark_hit[r]) begin
        w_busy_nxt[r] = 1'b1;
      end else if (w_wr_hit[r]) begin
        w_busy_nxt[r] = 1'b0;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Register array and busy bits, synchronous reset overrides writes and marks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      for (int r = 1; r < int'(DEPTH); r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      r_busy <= w_busy_nxt;
      for (int r = 1; r < int'(DEPTH); r++) begin
        r_regs[r] <= w_reg_nxt[r];
      end
    end
  end

  // Read ports: zero register, then youngest matching write bypass, then array.
  always_comb begin
    w_rd_busy = '0;
    for (int i = 0; i < int'(NUM_READ); i++) begin
      w_rd_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
      w_rd_data[i] = '0;
      if (w_rd_addr[i] != '0) begin
        w_rd_data[i] = r_regs[w_rd_addr[i]];
        w_rd_busy[i] = r_busy[w_rd_addr[i]];
        for (int j = 0; j < int'(NUM_WRITE); j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == w_rd_addr[i])) begin
            w_rd_data[i] = wr_data[j*DATA_W +: DATA_W];
            w_rd_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  // Flatten read results onto the output buses.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_READ); i++) begin
      rd_data[i*DATA_W +: DATA_W] = w_rd_data[i];
    end
    rd_busy = w_rd_busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven bench for regfile_mp with a scoreboard queue of
// expected read results, plus a hand-written mark/flush/write sequence.
module tb_regfile_mp;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned NUM_READ  = 4;
  localparam int unsigned NUM_WRITE = 2;
  localparam logic [31:0] DB        = 32'hDEADBEEF;

  logic                        clk;
  logic                        reset;
  logic [NUM_READ*ADDR_W-1:0]  rd_addr;
  logic [NUM_READ*DATA_W-1:0]  rd_data;
  logic [NUM_READ-1:0]         rd_busy;
  logic [NUM_WRITE-1:0]        wr_en;
  logic [NUM_WRITE*ADDR_W-1:0] wr_addr;
  logic [NUM_WRITE*DATA_W-1:0] wr_data;
  logic [NUM_WRITE-1:0]        mark_en;
  logic [NUM_WRITE*ADDR_W-1:0] mark_addr;
  logic                        flush;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ), .NUM_WRITE(NUM_WRITE)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  me;
    logic [4:0]  ma [2];
    logic [4:0]  ra [4];
    logic [31:0] ed [4];
    logic [3:0]  eb;
    bit          chk;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] d [4];
    logic [3:0]  b;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic [1:0] we,
                              input int wa0, input logic [31:0] wd0,
                              input int wa1, input logic [31:0] wd1,
                              input logic [1:0] me, input int ma0, input int ma1,
                              input int ra0, input int ra1, input int ra2, input int ra3,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic [31:0] ed2, input logic [31:0] ed3,
                              input logic [3:0] eb, input bit chk);
    vec_t v;
    v.rst = rst; v.fl = fl; v.we = we; v.me = me;
    v.wa[0] = 5'(wa0); v.wa[1] = 5'(wa1);
    v.wd[0] = wd0;     v.wd[1] = wd1;
    v.ma[0] = 5'(ma0); v.ma[1] = 5'(ma1);
    v.ra[0] = 5'(ra0); v.ra[1] = 5'(ra1); v.ra[2] = 5'(ra2); v.ra[3] = 5'(ra3);
    v.ed[0] = ed0; v.ed[1] = ed1; v.ed[2] = ed2; v.ed[3] = ed3;
    v.eb = eb; v.chk = chk;
    return v;
  endfunction

  // Drive one cycle of stimulus, push expectations, compare on the falling edge.
  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    reset     = v.rst;
    flush     = v.fl;
    wr_en     = v.we;
    wr_addr   = {v.wa[1], v.wa[0]};
    wr_data   = {v.wd[1], v.wd[0]};
    mark_en   = v.me;
    mark_addr = {v.ma[1], v.ma[0]};
    rd_addr   = {v.ra[3], v.ra[2], v.ra[1], v.ra[0]};
    if (v.chk) begin
      e.id = id; e.d = v.ed; e.b = v.eb;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (v.chk) begin
      e = sbq.pop_front();
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (rd_data[i*32 +: 32] !== e.d[i]) begin
          tests_failed++;
          $display("FAIL vec%0d rd_data[%0d]: got %h expected %h", e.id, i, rd_data[i*32 +: 32], e.d[i]);
        end
        tests_run++;
        if (rd_busy[i] !== e.b[i]) begin
          tests_failed++;
          $display("FAIL vec%0d rd_busy[%0d]: got %b expected %b", e.id, i, rd_busy[i], e.b[i]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1; flush = 1'b0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    mark_en = '0; mark_addr = '0; rd_addr = '0;

    //             rst fl  we     wa0 wd0            wa1 wd1            me     ma0 ma1  ra0..ra3      ed0..ed3                                            eb       chk
    vecs.push_back(mk(1, 0, 2'b11,  1, DB,            2, DB,            2'b01, 3, 0,  1, 2, 3, 0,   0, 0, 0, 0,                                         4'b0000, 0)); // 0 reset with writes/marks
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  1, 2, 3, 0,   0, 0, 0, 0,                                         4'b0000, 1)); // 1 reset beat writes
    vecs.push_back(mk(0, 0, 2'b11,  1, DB,            2, DB,            2'b11, 3, 4,  1, 2, 3, 4,   DB, DB, 0, 0,                                       4'b0000, 1)); // 2 write+mark
    vecs.push_back(mk(0, 0, 2'b01,  3, DB,            0, 0,             2'b00, 0, 0,  1, 2, 3, 4,   DB, DB, DB, 0,                                      4'b1000, 1)); // 3 r3 completes
    vecs.push_back(mk(1, 0, 2'b01,  5, 32'h1111,      0, 0,             2'b01, 6, 0,  1, 2, 3, 4,   DB, DB, DB, 0,                                      4'b1000, 1)); // 4 reset edge
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  1, 2, 3, 4,   0, 0, 0, 0,                                         4'b0000, 1)); // 5 cleared
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  5, 6, 0, 31,  0, 0, 0, 0,                                         4'b0000, 1)); // 6 cleared
    vecs.push_back(mk(0, 0, 2'b11,  5, 32'h12345678,  5, 32'hCAFEF00D,  2'b00, 0, 0,  5, 5, 0, 6,   32'hCAFEF00D, 32'hCAFEF00D, 0, 0,                   4'b0000, 1)); // 7 same-addr writes
    vecs.push_back(mk(0, 0, 2'b01,  0, 32'hFFFFFFFF,  0, 0,             2'b11, 0, 0,  5, 0, 0, 0,   32'hCAFEF00D, 0, 0, 0,                              4'b0000, 1)); // 8 r0 write+mark
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b10, 0, 7,  0, 5, 7, 7,   0, 32'hCAFEF00D, 0, 0,                              4'b0000, 1)); // 9 mark r7
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  7, 7, 7, 7,   0, 0, 0, 0,                                         4'b1111, 1)); // 10
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  7, 7, 7, 7,   0, 0, 0, 0,                                         4'b1111, 1)); // 11
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  7, 7, 7, 7,   0, 0, 0, 0,                                         4'b1111, 1)); // 12
    vecs.push_back(mk(0, 0, 2'b10,  0, 0,             7, 32'hA5A5A5A5,  2'b00, 0, 0,  7, 0, 7, 7,   32'hA5A5A5A5, 0, 32'hA5A5A5A5, 32'hA5A5A5A5,        4'b0000, 1)); // 13 write r7
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  7, 5, 7, 0,   32'hA5A5A5A5, 32'hCAFEF00D, 32'hA5A5A5A5, 0,        4'b0000, 1)); // 14
    vecs.push_back(mk(0, 0, 2'b01,  9, 32'h1,         0, 0,             2'b10, 0, 9,  9, 9, 0, 0,   32'h1, 32'h1, 0, 0,                                 4'b0000, 1)); // 15 write+mark r9
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  9, 9, 9, 9,   32'h1, 32'h1, 32'h1, 32'h1,                         4'b1111, 1)); // 16
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b11, 3, 4,  3, 4, 0, 0,   0, 0, 0, 0,                                         4'b0000, 1)); // 17 mark r3,r4
    vecs.push_back(mk(0, 1, 2'b10,  0, 0,            10, 32'h77,        2'b01, 6, 0,  3, 4, 6, 10,  0, 0, 0, 32'h77,                                    4'b0011, 1)); // 18 flush+mark r6
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  3, 4, 6, 10,  0, 0, 0, 32'h77,                                    4'b0000, 1)); // 19
    vecs.push_back(mk(0, 0, 2'b11,  3, 32'h3,        11, 32'h55,        2'b01, 11, 0, 11, 3, 0, 0,  32'h55, 32'h3, 0, 0,                                4'b0000, 1)); // 20 mark beats write
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  11, 3, 11, 3, 32'h55, 32'h3, 32'h55, 32'h3,                       4'b0101, 1)); // 21
    vecs.push_back(mk(0, 0, 2'b01, 31, 32'hFFFF0000,  0, 0,             2'b00, 0, 0,  31, 11, 0, 31, 32'hFFFF0000, 32'h55, 0, 32'hFFFF0000,             4'b0010, 1)); // 22 top register
    vecs.push_back(mk(0, 0, 2'b00,  0, 0,             0, 0,             2'b00, 0, 0,  31, 31, 31, 31, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 4'b0000, 1)); // 23

    @(posedge clk);
    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      run_vec(vecs[k], k);
    end

    // Hand sequence: mark r20, hold busy, flush drops it, later write still lands.
    run_vec(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 20, 0, 0, 0, 20, 0, 0, 0, 0, 4'b0000, 1), 100);
    for (int c = 0; c < 3; c++) begin
      run_vec(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 4'b1000, 1), 101 + c);
    end
    run_vec(mk(0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 4'b1000, 1), 104);
    run_vec(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 4'b0000, 1), 105);
    run_vec(mk(0, 0, 2'b01, 20, 32'h20, 0, 0, 2'b00, 0, 0, 20, 0, 0, 20, 32'h20, 0, 0, 32'h20, 4'b0000, 1), 106);
    run_vec(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 20, 20, 20, 20, 32'h20, 32'h20, 32'h20, 32'h20, 4'b0000, 1), 107);

    tests_run++;
    if (sbq.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
